// File: rtl/spectrum_peak_tracker_pkg.sv
// Shared types and constants for the spectrum peak tracker.
// Result fields are sized for the default geometry (up to 256 bins, 32-bit magnitudes).
package spectrum_peak_tracker_pkg;

   localparam int N_BINS_DEF = 256;
   localparam int BIN_W_DEF  = $clog2(N_BINS_DEF);
   localparam int MAG_W_DEF  = 32;

   typedef enum logic [0:0] {
      ACC    = 1'b0,
      RESYNC = 1'b1
   } trk_state_t;

   typedef struct packed {
      logic [BIN_W_DEF-1:0] bin;
      logic [MAG_W_DEF-1:0] mag;
      logic                 hit;
   } peak_result_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] res;
      if (value == 8'hFF) begin
         res = value;
      end else begin
         res = value + 8'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/spectrum_peak_tracker_peak_out_reg.sv
// One-entry valid/ready result register with a saturating count of results
// that arrived while an unaccepted result was still held.
module peak_out_reg
   import spectrum_peak_tracker_pkg::*;
#(
   parameter int BIN_W = BIN_W_DEF,
   parameter int MAG_W = MAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  peak_result_t     result,
   input  logic             peak_ready,
   output logic             peak_valid,
   output logic [BIN_W-1:0] peak_bin,
   output logic [MAG_W-1:0] peak_mag,
   output logic             peak_hit,
   output logic [7:0]       drop_cnt
);

   logic             valid_r;
   logic [BIN_W-1:0] bin_r;
   logic [MAG_W-1:0] mag_r;
   logic             hit_r;
   logic [7:0]       drop_r;

   logic             valid_s;
   logic [BIN_W-1:0] bin_s;
   logic [MAG_W-1:0] mag_s;
   logic             hit_s;
   logic [7:0]       drop_s;

   // Next-state: a completion in the same cycle as a handshake replaces the entry.
   always_comb begin
      valid_s = valid_r;
      bin_s   = bin_r;
      mag_s   = mag_r;
      hit_s   = hit_r;
      drop_s  = drop_r;
      if (load) begin
         if (valid_r && !peak_ready) begin
            drop_s = sat_inc8(drop_r);
         end else begin
            valid_s = 1'b1;
            bin_s   = result.bin[BIN_W-1:0];
            mag_s   = result.mag[MAG_W-1:0];
            hit_s   = result.hit;
         end
      end else if (valid_r && peak_ready) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end
   end

   // Output register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         bin_r   <= {BIN_W{1'b0}};
         mag_r   <= {MAG_W{1'b0}};
         hit_r   <= 1'b0;
         drop_r  <= 8'd0;
      end else begin
         valid_r <= valid_s;
         bin_r   <= bin_s;
         mag_r   <= mag_s;
         hit_r   <= hit_s;
         drop_r  <= drop_s;
      end
   end

   assign peak_valid = valid_r;
   assign peak_bin   = bin_r;
   assign peak_mag   = mag_r;
   assign peak_hit   = hit_r;
   assign drop_cnt   = drop_r;

endmodule

// File: rtl/spectrum_peak_tracker.sv
// Per-frame peak detector: tracks the running maximum bin of each frame,
// validates frame length and hands completed results to a valid/ready register.
module spectrum_peak_tracker
   import spectrum_peak_tracker_pkg::*;
#(
   parameter int N_BINS = N_BINS_DEF,
   parameter int BIN_W  = $clog2(N_BINS),
   parameter int MAG_W  = MAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spec_valid,
   input  logic [MAG_W-1:0] spec_data,
   input  logic             spec_last,
   input  logic [MAG_W-1:0] threshold,
   output logic             peak_valid,
   input  logic             peak_ready,
   output logic [BIN_W-1:0] peak_bin,
   output logic [MAG_W-1:0] peak_mag,
   output logic             peak_hit,
   output logic             frame_err,
   output logic [7:0]       drop_cnt
);

   localparam logic [BIN_W-1:0] BIN_ZERO = {BIN_W{1'b0}};
   localparam logic [BIN_W-1:0] BIN_ONE  = {{(BIN_W-1){1'b0}}, 1'b1};
   localparam logic [BIN_W-1:0] BIN_LAST = {BIN_W{1'b1}};

   trk_state_t       state_r;
   logic [BIN_W-1:0] cnt_r;
   logic [MAG_W-1:0] max_r;
   logic [BIN_W-1:0] idx_r;
   logic [MAG_W-1:0] thr_r;
   logic             frame_err_r;

   trk_state_t       state_s;
   logic [BIN_W-1:0] cnt_s;
   logic [MAG_W-1:0] max_s;
   logic [BIN_W-1:0] idx_s;
   logic [MAG_W-1:0] thr_s;
   logic             err_s;
   logic             done_s;
   logic [MAG_W-1:0] beat_max_s;
   logic [BIN_W-1:0] beat_idx_s;
   logic [MAG_W-1:0] beat_thr_s;
   peak_result_t     result_s;

   // Running max including the current beat; bin 0 restarts it, ties keep the older bin.
   always_comb begin
      beat_max_s = max_r;
      beat_idx_s = idx_r;
      beat_thr_s = thr_r;
      if (cnt_r == BIN_ZERO) begin
         beat_max_s = spec_data;
         beat_idx_s = BIN_ZERO;
         beat_thr_s = threshold;
      end else if (spec_data > max_r) begin
         beat_max_s = spec_data;
         beat_idx_s = cnt_r;
      end else begin
         beat_max_s = max_r;
         beat_idx_s = idx_r;
      end
   end

   // Frame tracker next-state: length checking and resynchronisation.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      max_s   = max_r;
      idx_s   = idx_r;
      thr_s   = thr_r;
      err_s   = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         ACC: begin
            if (spec_valid) begin
               max_s = beat_max_s;
               idx_s = beat_idx_s;
               thr_s = beat_thr_s;
               if (spec_last) begin
                  cnt_s = BIN_ZERO;
                  if (cnt_r == BIN_LAST) begin
                     done_s = 1'b1;
                  end else begin
                     err_s = 1'b1;
                  end
               end else if (cnt_r == BIN_LAST) begin
                  err_s   = 1'b1;
                  cnt_s   = BIN_ZERO;
                  state_s = RESYNC;
               end else begin
                  cnt_s = cnt_r + BIN_ONE;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         RESYNC: begin
            if (spec_valid && spec_last) begin
               state_s = ACC;
               cnt_s   = BIN_ZERO;
            end else begin
               state_s = RESYNC;
            end
         end
         default: begin
            state_s = ACC;
            cnt_s   = BIN_ZERO;
         end
      endcase
   end

   // Result packing for the output stage.
   always_comb begin
      result_s     = '{default: 1'b0};
      result_s.bin = BIN_W_DEF'(beat_idx_s);
      result_s.mag = MAG_W_DEF'(beat_max_s);
      result_s.hit = (beat_max_s >= beat_thr_s);
   end

   // Frame tracker state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ACC;
         cnt_r       <= BIN_ZERO;
         max_r       <= {MAG_W{1'b0}};
         idx_r       <= BIN_ZERO;
         thr_r       <= {MAG_W{1'b0}};
         frame_err_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         max_r       <= max_s;
         idx_r       <= idx_s;
         thr_r       <= thr_s;
         frame_err_r <= err_s;
      end
   end

   assign frame_err = frame_err_r;

   peak_out_reg #(
      .BIN_W (BIN_W),
      .MAG_W (MAG_W)
   ) u_peak_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (done_s),
      .result     (result_s),
      .peak_ready (peak_ready),
      .peak_valid (peak_valid),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
      .peak_hit   (peak_hit),
      .drop_cnt   (drop_cnt)
   );

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// Directed self-checking bench for spectrum_peak_tracker with 8-bin frames.
module tb_spectrum_peak_tracker;

   localparam int N_BINS = 8;
   localparam int BIN_W  = 3;
   localparam int MAG_W  = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             spec_valid;
   logic [MAG_W-1:0] spec_data;
   logic             spec_last;
   logic [MAG_W-1:0] threshold;
   logic             peak_valid;
   logic             peak_ready;
   logic [BIN_W-1:0] peak_bin;
   logic [MAG_W-1:0] peak_mag;
   logic             peak_hit;
   logic             frame_err;
   logic [7:0]       drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spectrum_peak_tracker #(.N_BINS(N_BINS), .BIN_W(BIN_W), .MAG_W(MAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spec_valid (spec_valid),
      .spec_data  (spec_data),
      .spec_last  (spec_last),
      .threshold  (threshold),
      .peak_valid (peak_valid),
      .peak_ready (peak_ready),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
      .peak_hit   (peak_hit),
      .frame_err  (frame_err),
      .drop_cnt   (drop_cnt)
   );

   task automatic beat(input logic [31:0] d, input logic l);
      spec_valid = 1'b1;
      spec_data  = d;
      spec_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      spec_valid = 1'b0;
      spec_last  = 1'b0;
      spec_data  = 32'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] v [8]);
      for (int i = 0; i < 8; i++) beat(v[i], (i == 7));
   endtask

   task automatic consume();
      peak_ready = 1'b1;
      idle(1);
      peak_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; spec_valid = 1'b0; spec_last = 1'b0; spec_data = 32'd0;
      threshold = 32'd0; peak_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", peak_valid); end
      checks++; if (peak_bin !== 3'd0) begin errors++; $display("FAIL reset_bin got %0d want 0", peak_bin); end
      checks++; if (peak_mag !== 32'd0) begin errors++; $display("FAIL reset_mag got %0d want 0", peak_mag); end
      checks++; if (peak_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", peak_hit); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", frame_err); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
   endtask

   task automatic test_basic_peak();
      logic [31:0] v [8];
      v = '{32'd3, 32'd9, 32'd2, 32'd9, 32'd1, 32'd0, 32'd5, 32'd4};
      threshold = 32'd8;
      for (int i = 0; i < 7; i++) beat(v[i], 1'b0);
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", peak_valid); end
      beat(v[7], 1'b1);
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", peak_valid); end
      checks++; if (peak_bin !== 3'd1) begin errors++; $display("FAIL basic_bin got %0d want 1", peak_bin); end
      checks++; if (peak_mag !== 32'd9) begin errors++; $display("FAIL basic_mag got %0d want 9", peak_mag); end
      checks++; if (peak_hit !== 1'b1) begin errors++; $display("FAIL basic_hit got %0b want 1", peak_hit); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_err got %0b want 0", frame_err); end
      idle(2);
      checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL basic_hold got %0b want 1", peak_valid); end
      consume();
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL basic_clear got %0b want 0", peak_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [8];
      logic [31:0] vb [8];
      logic [31:0] vc [8];
      va = '{32'd1, 32'd2, 32'd3, 32'd20, 32'd4, 32'd5, 32'd6, 32'd7};
      vb = '{32'd30, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      vc = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd6, 32'd5};
      peak_ready = 1'b0;
      send_frame(va);
      checks++; if (peak_bin !== 3'd3 || peak_mag !== 32'd20) begin errors++; $display("FAIL b2b_first got bin %0d mag %0d want 3/20", peak_bin, peak_mag); end
      send_frame(vb);
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL b2b_held_valid got %0b want 1", peak_valid); end
      checks++; if (peak_bin !== 3'd3 || peak_mag !== 32'd20 || peak_hit !== 1'b1) begin errors++; $display("FAIL b2b_held got bin %0d mag %0d hit %0b want 3/20/1", peak_bin, peak_mag, peak_hit); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL b2b_drop got %0d want 1", drop_cnt); end
      consume();
      send_frame(vc);
      checks++; if (peak_bin !== 3'd5 || peak_mag !== 32'd7 || peak_hit !== 1'b0) begin errors++; $display("FAIL b2b_c got bin %0d mag %0d hit %0b want 5/7/0", peak_bin, peak_mag, peak_hit); end
      for (int i = 0; i < 7; i++) beat(32'd2, 1'b0);
      peak_ready = 1'b1;
      beat(32'd50, 1'b1);
      peak_ready = 1'b0;
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL b2b_replace_valid got %0b want 1", peak_valid); end
      checks++; if (peak_bin !== 3'd7 || peak_mag !== 32'd50 || peak_hit !== 1'b1) begin errors++; $display("FAIL b2b_replace got bin %0d mag %0d hit %0b want 7/50/1", peak_bin, peak_mag, peak_hit); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL b2b_replace_drop got %0d want 1", drop_cnt); end
      consume();
   endtask

   task automatic test_early_last();
      logic [31:0] v [8];
      v = '{32'd40, 32'd40, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      for (int i = 0; i < 4; i++) beat(32'd5, 1'b0);
      beat(32'd5, 1'b1);
      spec_valid = 1'b0;
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err got %0b want 1", frame_err); end
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %0b want 0", peak_valid); end
      idle(1);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_err_pulse got %0b want 0", frame_err); end
      send_frame(v);
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1 || peak_bin !== 3'd0 || peak_mag !== 32'd40) begin errors++; $display("FAIL early_next got v %0b bin %0d mag %0d want 1/0/40", peak_valid, peak_bin, peak_mag); end
      consume();
   endtask

   task automatic test_missing_last();
      logic [31:0] v [8];
      int err_seen;
      v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd8, 32'd7};
      err_seen = 0;
      for (int i = 0; i < 8; i++) begin
         beat(32'd100, 1'b0);
         if (frame_err === 1'b1) err_seen++;
      end
      for (int i = 0; i < 3; i++) begin
         beat(32'd200, (i == 2));
         if (frame_err === 1'b1) err_seen++;
      end
      spec_valid = 1'b0;
      checks++; if (err_seen !== 1) begin errors++; $display("FAIL missing_err_count got %0d want 1", err_seen); end
      checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL missing_valid got %0b want 0", peak_valid); end
      send_frame(v);
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1 || peak_bin !== 3'd6 || peak_mag !== 32'd8 || peak_hit !== 1'b1) begin errors++; $display("FAIL missing_next got v %0b bin %0d mag %0d hit %0b want 1/6/8/1", peak_valid, peak_bin, peak_mag, peak_hit); end
      consume();
   endtask

   task automatic test_threshold_reset();
      logic [31:0] v [8];
      v = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
      threshold = 32'd10;
      beat(32'd1, 1'b0); beat(32'd5, 1'b0); beat(32'd2, 1'b0); beat(32'd3, 1'b0);
      threshold = 32'd2;
      beat(32'd0, 1'b0); beat(32'd0, 1'b0); beat(32'd0, 1'b0); beat(32'd0, 1'b1);
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1 || peak_bin !== 3'd1 || peak_mag !== 32'd5 || peak_hit !== 1'b0) begin errors++; $display("FAIL thr_frame got v %0b bin %0d mag %0d hit %0b want 1/1/5/0", peak_valid, peak_bin, peak_mag, peak_hit); end
      beat(32'd9, 1'b0); beat(32'd9, 1'b0); beat(32'd9, 1'b0);
      spec_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #2;
      checks++; if (peak_valid !== 1'b0 || peak_bin !== 3'd0 || peak_mag !== 32'd0 || peak_hit !== 1'b0) begin errors++; $display("FAIL rst_outputs got v %0b bin %0d mag %0d hit %0b want 0/0/0/0", peak_valid, peak_bin, peak_mag, peak_hit); end
      checks++; if (drop_cnt !== 8'd0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_drop_err got %0d/%0b want 0/0", drop_cnt, frame_err); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(v);
      spec_valid = 1'b0;
      checks++; if (peak_valid !== 1'b1 || peak_bin !== 3'd2 || peak_mag !== 32'd3 || peak_hit !== 1'b1) begin errors++; $display("FAIL rst_next got v %0b bin %0d mag %0d hit %0b want 1/2/3/1", peak_valid, peak_bin, peak_mag, peak_hit); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_next_err got %0b want 0", frame_err); end
      consume();
   endtask

   task automatic test_saturation();
      logic [31:0] v [8];
      v = '{32'd7, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      peak_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
         send_frame(v);
         if (i == 254) begin
            checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", drop_cnt); end
         end
      end
      spec_valid = 1'b0;
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", drop_cnt); end
      checks++; if (peak_valid !== 1'b1 || peak_bin !== 3'd0 || peak_mag !== 32'd7) begin errors++; $display("FAIL sat_held got v %0b bin %0d mag %0d want 1/0/7", peak_valid, peak_bin, peak_mag); end
      consume();
   endtask

   initial begin
      test_reset();
      test_basic_peak();
      test_back_to_back();
      test_early_last();
      test_missing_last();
      test_threshold_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
